// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial add/subtract, one full-adder slice, LSB first. Ports: clk, rst_n (async active-low), start/sub/a/b in; busy, done, sum, cout, ovf (only with SERIAL_ADD_OVF_EN) out.
module serial_add_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-2:0] rs;
  logic [CW-1:0]    cnt;
  logic             carry, s, c, last;
  logic [WIDTH-1:0] nxt;
  assign s    = ra[0] ^ rb[0] ^ carry;
  assign c    = (ra[0] & rb[0]) | ((ra[0] ^ rb[0]) & carry);
  assign last = cnt == CW'(WIDTH - 1);
  // result bits enter at the MSB; after the last bit nxt holds the full sum
  assign nxt  = {s, rs};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          rs    <= nxt[WIDTH-1:1];
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= nxt;
            cout  <= c;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ c;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= start ? RUN : IDLE;
          if (start) begin
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
